dds_note_sequencer: RTL and testbench

- Drives the DDS core as a tone sequencer.
- Holds a small table of notes. Each entry is a 22-bit phase increment plus a duration in samples.
- Generates the sampling_pulse strobe at a fixed clock division and presents each note's k to the DDS for its programmed number of samples.
- Sits between the host/control logic and the DDS. Its k and sampling_pulse outputs feed the DDS k and sampling_pulse inputs directly.

---
 rtl/dds_note_sequencer.sv | 152 +++++++++++++++
 tb/tb_dds_note_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dds_note_sequencer.sv
// Tone sequencer for the DDS: walks a small note table, presenting each entry's
// phase increment for its programmed number of sample periods.
module dds_note_sequencer #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int SAMPLE_DIV = 1000,
    parameter int DIV_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [21:0]   wr_k,
    input  logic [15:0]   wr_dur,
    output logic [21:0]   k,
    output logic          sampling_pulse,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] note_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] note_idx_reg, note_idx_next;
    logic [15:0]   dur_cnt_reg, dur_cnt_next;
    logic [21:0]   k_reg, k_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic          sampling_pulse_reg, sampling_pulse_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [21:0]      tbl_k   [DEPTH];
    logic [15:0]      tbl_dur [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             eos_restart;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    // Table is cleared on reset, so it is held in flops rather than block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_k[i]   <= '0;
                tbl_dur[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    tbl_k[i]   <= wr_k;
                    tbl_dur[i] <= wr_dur;
                end
            end
        end
    end

    assign eos_restart = loop && (tbl_dur[0] != 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            note_idx_reg       <= '0;
            dur_cnt_reg        <= '0;
            k_reg              <= '0;
            div_cnt_reg        <= '0;
            sampling_pulse_reg <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            note_idx_reg       <= note_idx_next;
            dur_cnt_reg        <= dur_cnt_next;
            k_reg              <= k_next;
            div_cnt_reg        <= div_cnt_next;
            sampling_pulse_reg <= sampling_pulse_next;
            busy_reg           <= busy_next;
            done_reg           <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        note_idx_next = note_idx_reg;
        dur_cnt_next  = dur_cnt_reg;
        k_next        = k_reg;
        case (state_reg)
            ST_IDLE: begin
                note_idx_next = '0;
                if (start && !stop) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (tbl_dur[note_idx_reg] == 16'd0) begin
                    state_next    = eos_restart ? ST_LOAD : ST_DONE;
                    note_idx_next = '0;
                end else begin
                    k_next       = tbl_k[note_idx_reg];
                    dur_cnt_next = tbl_dur[note_idx_reg];
                    state_next   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // k is left untouched here so the final sample of the note uses it.
                if (sampling_pulse_reg) begin
                    dur_cnt_next = dur_cnt_reg - 16'd1;
                    if (dur_cnt_reg == 16'd1) begin
                        if (note_idx_reg == AW'(DEPTH - 1)) begin
                            state_next    = eos_restart ? ST_LOAD : ST_DONE;
                            note_idx_next = '0;
                        end else begin
                            state_next    = ST_LOAD;
                            note_idx_next = note_idx_reg + AW'(1);
                        end
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                note_idx_next = '0;
            end
        endcase
        if (stop && (state_reg == ST_LOAD || state_reg == ST_PLAY)) begin
            state_next    = ST_IDLE;
            note_idx_next = '0;
        end
        if (state_next == ST_IDLE || state_next == ST_DONE) k_next = '0;
    end

    always_comb begin
        busy_next = (state_next == ST_LOAD) || (state_next == ST_PLAY);
        done_next = (state_next == ST_DONE);
        if (busy_next && busy_reg)
            div_cnt_next = (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt_reg + DIV_W'(1);
        else
            div_cnt_next = '0;
        sampling_pulse_next = (div_cnt_next == DIV_W'(SAMPLE_DIV - 1));
    end

    assign k              = k_reg;
    assign sampling_pulse = sampling_pulse_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign note_idx       = note_idx_reg;

endmodule

// File: tb/tb_dds_note_sequencer.sv
// Scoreboard bench: expected k per sample pulse is queued with the stimulus and
// compared whenever the sequencer emits sampling_pulse.
module tb_dds_note_sequencer;
    localparam int AW = 2, DEPTH = 4, SD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [21:0]   wr_k = '0;
    logic [15:0]   wr_dur = '0;
    logic [21:0]   k;
    logic          sampling_pulse, busy, done;
    logic [AW-1:0] note_idx;

    dds_note_sequencer #(.DEPTH(DEPTH), .AW(AW), .SAMPLE_DIV(SD), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_k(wr_k), .wr_dur(wr_dur),
        .k(k), .sampling_pulse(sampling_pulse), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, pulse_cnt = 0, s_cyc = 0, last_pulse = 0;
    bit first_pending = 1'b0;
    logic [21:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sampling_pulse) begin
            pulse_cnt++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("pulse_k", 32'(k), 32'(sb.pop_front()));
            if (first_pending) check("first_pulse_lat", 32'(cyc - s_cyc), 32'(SD));
            else               check("pulse_gap", 32'(cyc - last_pulse), 32'(SD));
            first_pending = 1'b0;
            last_pulse = cyc;
            $display("pulse %0d at cycle %0d k=0x%0h note_idx=%0d", pulse_cnt, cyc, k, note_idx);
        end
    end

    task automatic wr(input int a, input int kk, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_k = 22'(kk); wr_dur = 16'(d);
        @(negedge clk);
        wr_en = 1'b0;
        $display("write e%0d k=0x%0h dur=%0d", a, kk, d);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1; s_cyc = cyc; first_pending = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input int kk, input int n);
        for (int i = 0; i < n; i++) sb.push_back(22'(kk));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        check(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_sb(input string tag, input int left, input int budget);
        for (int i = 0; i < budget && sb.size() > left; i++) @(negedge clk);
        check(tag, 32'(sb.size()), 32'(left));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_k"}, 32'(k), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_idx"}, 32'(note_idx), 32'd0);
    endtask

    initial begin
        int d0, p0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_pulse", 32'(sampling_pulse), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // basic playback
        wr(0, 'h100, 2); wr(1, 'h200, 3); wr(2, 0, 0);
        push('h100, 2); push('h200, 3);
        d0 = done_cnt;
        do_start();
        check("basic_busy", 32'(busy), 32'd1);
        wait_done("basic_done", 100);
        @(negedge clk);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);
        check("basic_done_once", 32'(done_cnt - d0), 32'd1);
        check_idle("basic_end");

        // stop during e1, then replay from e0
        push('h100, 2); push('h200, 1);
        d0 = done_cnt;
        do_start();
        wait_sb("stop_reach_e1", 0, 100);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check_idle("stop");
        p0 = pulse_cnt;
        repeat (12) @(negedge clk);
        check("stop_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("stop_no_done", 32'(done_cnt - d0), 32'd0);
        push('h100, 2); push('h200, 3);
        do_start();
        wait_done("replay_done", 100);
        check("replay_sb_empty", 32'(sb.size()), 32'd0);

        // full table, no marker
        wr(0, 'h11, 1); wr(1, 'h22, 1); wr(2, 'h33, 1); wr(3, 'h44, 1);
        push('h11, 1); push('h22, 1); push('h33, 1); push('h44, 1);
        do_start();
        wait_done("full_done", 100);
        @(negedge clk);
        check("full_sb_empty", 32'(sb.size()), 32'd0);
        check_idle("full_end");

        // loop on a single note, then drop loop
        wr(0, 'h10, 1); wr(1, 0, 0);
        loop = 1'b1;
        push('h10, 8);
        d0 = done_cnt;
        do_start();
        wait_sb("loop_pulses", 0, 200);
        check("loop_no_done", 32'(done_cnt - d0), 32'd0);
        check("loop_busy", 32'(busy), 32'd1);
        loop = 1'b0;
        wait_done("loop_exit_done", 12);
        check_idle("loop_end");

        // empty table with loop
        wr(0, 0, 0);
        loop = 1'b1;
        p0 = pulse_cnt;
        do_start();
        wait_done("empty_done", 2);
        check("empty_no_pulse", 32'(pulse_cnt - p0), 32'd0);

        // rewrite e0 while it plays, then reset mid-PLAY
        wr(0, 'h100, 2);
        push('h100, 2); push('h300, 2);
        do_start();
        wait_sb("wdp_first", 3, 100);
        wr(0, 'h300, 2);
        wait_sb("wdp_new_k", 0, 100);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_idle("rst_mid");
        check("rst_mid_pulse", 32'(sampling_pulse), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        loop = 1'b0;
        p0 = pulse_cnt;
        do_start();
        wait_done("cleared_done", 2);
        check("cleared_no_pulse", 32'(pulse_cnt - p0), 32'd0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
